// File: rtl/data_memory_rv64.sv
// Doubleword data memory for the single-cycle RV64 datapath: synchronous
// whole-word writes, combinational gated read, asynchronous clear of every word.
module data_memory_rv64 #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic [63:0] read_data
);

  logic [ADDR_W-1:0] index;
  logic [63:0]       word_bus [DEPTH];
  logic              addr_unused;

  // Byte offset and high bits are dropped, so accesses alias modulo DEPTH*8 bytes.
  assign index       = address[ADDR_W+2:3];
  assign addr_unused = ^{address[63:ADDR_W+3], address[2:0]};

  // Each word is its own register so the whole array clears without a clock.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [63:0] word_d;
      logic [63:0] word_q;

      always_comb begin
        word_d = word_q;
        if (mem_write && (index == ADDR_W'(gi))) begin
          word_d = write_data;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign word_bus[gi] = word_q;
    end
  endgenerate

  always_comb begin
    read_data = '0;
    if (mem_read && rst) begin
      read_data = word_bus[index];
    end
  end

endmodule

// File: tb/tb_data_memory_rv64.sv
// Directed self-checking bench for data_memory_rv64: reset clear, write/read,
// alignment, aliasing, read gating, same-cycle read/write and async reset.
module tb_data_memory_rv64;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  int checks_cnt;
  int errors_cnt;

  data_memory_rv64 #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end else begin
      $display("ok   %s observed=%h", tag, observed);
    end
  endtask

  task automatic write_word(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = addr;
    write_data = data;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [63:0] addr, input logic [63:0] expected);
    @(negedge clk);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    address   = addr;
    #1;
    check(tag, read_data, expected);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst        = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    address    = 64'h10;
    write_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("read_in_reset", read_data, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    read_check("reset_clear_0x10", 64'h10, 64'h0);

    write_word(64'h10, 64'h1234_5678_9ABC_DEF0);
    check("write_rd_gated", read_data, 64'h0);
    read_check("read_0x10", 64'h10, 64'h1234_5678_9ABC_DEF0);

    write_word(64'h20, 64'hFEDC_BA98_7654_3210);
    read_check("read_0x10_again", 64'h10, 64'h1234_5678_9ABC_DEF0);
    read_check("read_0x20", 64'h20, 64'hFEDC_BA98_7654_3210);
    read_check("read_0x18_empty", 64'h18, 64'h0);

    read_check("unaligned_0x17", 64'h17, 64'h1234_5678_9ABC_DEF0);
    read_check("unaligned_0x23", 64'h23, 64'hFEDC_BA98_7654_3210);
    read_check("alias_depth", 64'h10 + 64'(DEPTH * 8), 64'h1234_5678_9ABC_DEF0);
    read_check("alias_high_bits", 64'hFFFF_0000_0000_0020, 64'hFEDC_BA98_7654_3210);
    read_check("top_word_empty", 64'(DEPTH * 8 - 8), 64'h0);

    @(negedge clk);
    mem_read = 1'b0;
    address  = 64'h10;
    #1;
    check("read_gated", read_data, 64'h0);

    // Same-cycle read and write at 0x30: old (zero) before the edge, new after.
    @(negedge clk);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    address    = 64'h30;
    write_data = 64'hAAAA_AAAA_AAAA_AAAA;
    #1;
    check("rw_before_edge", read_data, 64'h0);
    @(posedge clk);
    #1;
    check("rw_after_edge", read_data, 64'hAAAA_AAAA_AAAA_AAAA);
    mem_write = 1'b0;

    // Top word written, then overwritten, checks the highest index.
    write_word(64'(DEPTH * 8 - 8), 64'h0123_4567_89AB_CDEF);
    write_word(64'(DEPTH * 8 - 1), 64'h5555_0000_FFFF_1111);
    read_check("top_word_overwrite", 64'(DEPTH * 8 - 8), 64'h5555_0000_FFFF_1111);

    // Asynchronous reset between edges, with a write attempted during reset.
    @(negedge clk);
    mem_read = 1'b1;
    address  = 64'h10;
    #1;
    check("pre_async_reset", read_data, 64'h1234_5678_9ABC_DEF0);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_now", read_data, 64'h0);
    mem_write  = 1'b1;
    address    = 64'h40;
    write_data = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    read_check("post_reset_0x10", 64'h10, 64'h0);
    read_check("post_reset_0x20", 64'h20, 64'h0);
    read_check("post_reset_0x30", 64'h30, 64'h0);
    read_check("write_in_reset_0x40", 64'h40, 64'h0);

    write_word(64'h40, 64'h0F0F_0F0F_0F0F_0F0F);
    read_check("write_after_reset", 64'h40, 64'h0F0F_0F0F_0F0F_0F0F);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
